// File: rtl/movegen_pkg.sv
// Shared widths, piece type and load-FSM state encoding for the
// move-generator board store.
package movegen_pkg;

  localparam int unsigned PIECE_W_DEF = 4;
  localparam int unsigned SQ_W_DEF    = 6;

  typedef logic [PIECE_W_DEF-1:0] piece_t;

  localparam piece_t PIECE_EMPTY = '0;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_LOAD = 1'b1
  } load_state_t;

endpackage

// File: rtl/board_bank.sv
// One board register file: a single write port and N_LOOKUP combinational
// read ports. Contents clear on reset.
module board_bank
  import movegen_pkg::*;
#(
  parameter int unsigned PIECE_W  = PIECE_W_DEF,
  parameter int unsigned SQ_W     = SQ_W_DEF,
  parameter int unsigned N_LOOKUP = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [SQ_W-1:0]              wr_addr,
  input  logic [PIECE_W-1:0]           wr_data,
  input  logic [N_LOOKUP*SQ_W-1:0]     rd_addr,
  output logic [N_LOOKUP*PIECE_W-1:0]  rd_data
);

  localparam int unsigned N_SQ = 2**SQ_W;

  logic [PIECE_W-1:0] mem_q [N_SQ];
  logic [PIECE_W-1:0] mem_d [N_SQ];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_SQ; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < N_LOOKUP; i++) begin
      rd_data[i*PIECE_W +: PIECE_W] = mem_q[rd_addr[i*SQ_W +: SQ_W]];
    end
  end

endmodule

// File: rtl/movegen_board_store.sv
// Double-buffered board store: a streamed position fills the shadow bank and
// is swapped live on its last square; lookup ports read the live bank.
module movegen_board_store
  import movegen_pkg::*;
#(
  parameter int unsigned PIECE_W  = PIECE_W_DEF,
  parameter int unsigned SQ_W     = SQ_W_DEF,
  parameter int unsigned N_LOOKUP = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_pos_valid,
  input  logic [PIECE_W-1:0]           in_pos_data,
  input  logic                         in_pos_sop,
  input  logic [N_LOOKUP-1:0]          lookup_valid,
  input  logic [N_LOOKUP*SQ_W-1:0]     lookup_rankfile,
  output logic [N_LOOKUP*PIECE_W-1:0]  out_piece,
  output logic [N_LOOKUP-1:0]          out_piece_valid,
  output logic                         board_ready,
  output logic [7:0]                   board_seq,
  output logic                         frame_err
);

  load_state_t                 state_q, state_d;
  logic [SQ_W-1:0]             wr_idx_q, wr_idx_d;
  logic                        live_sel_q, live_sel_d;
  logic [7:0]                  board_seq_q, board_seq_d;
  logic                        board_ready_q, board_ready_d;
  logic                        frame_err_q, frame_err_d;
  logic [N_LOOKUP*PIECE_W-1:0] out_piece_q, out_piece_d;
  logic [N_LOOKUP-1:0]         out_piece_valid_q, out_piece_valid_d;

  logic                        wr_en;
  logic [SQ_W-1:0]             wr_addr;
  logic [N_LOOKUP*PIECE_W-1:0] rd_data0, rd_data1, live_rd;

  // Bank 0 is the shadow while live_sel is 1, bank 1 while it is 0.
  board_bank #(
    .PIECE_W (PIECE_W),
    .SQ_W    (SQ_W),
    .N_LOOKUP(N_LOOKUP)
  ) u_bank0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en & live_sel_q),
    .wr_addr(wr_addr),
    .wr_data(in_pos_data),
    .rd_addr(lookup_rankfile),
    .rd_data(rd_data0)
  );

  board_bank #(
    .PIECE_W (PIECE_W),
    .SQ_W    (SQ_W),
    .N_LOOKUP(N_LOOKUP)
  ) u_bank1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en & ~live_sel_q),
    .wr_addr(wr_addr),
    .wr_data(in_pos_data),
    .rd_addr(lookup_rankfile),
    .rd_data(rd_data1)
  );

  assign live_rd = live_sel_q ? rd_data1 : rd_data0;

  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    live_sel_d    = live_sel_q;
    board_seq_d   = board_seq_q;
    board_ready_d = board_ready_q;
    frame_err_d   = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = wr_idx_q;

    if (in_pos_valid) begin
      case (state_q)
        LD_IDLE: begin
          if (in_pos_sop) begin
            wr_en    = 1'b1;
            wr_addr  = '0;
            wr_idx_d = SQ_W'(1);
            state_d  = LD_LOAD;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        LD_LOAD: begin
          if (in_pos_sop) begin
            // Restart: the partial frame is simply overwritten in the shadow.
            frame_err_d = 1'b1;
            wr_en       = 1'b1;
            wr_addr     = '0;
            wr_idx_d    = SQ_W'(1);
          end else begin
            wr_en    = 1'b1;
            wr_idx_d = wr_idx_q + SQ_W'(1);
            if (wr_idx_q == '1) begin
              live_sel_d    = ~live_sel_q;
              board_seq_d   = board_seq_q + 8'd1;
              board_ready_d = 1'b1;
              state_d       = LD_IDLE;
            end
          end
        end
        default: state_d = LD_IDLE;
      endcase
    end
  end

  always_comb begin
    out_piece_d       = out_piece_q;
    out_piece_valid_d = lookup_valid;
    for (int unsigned i = 0; i < N_LOOKUP; i++) begin
      if (lookup_valid[i]) begin
        out_piece_d[i*PIECE_W +: PIECE_W] = board_ready_q ? live_rd[i*PIECE_W +: PIECE_W]
                                                          : PIECE_W'(PIECE_EMPTY);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= LD_IDLE;
      wr_idx_q          <= '0;
      live_sel_q        <= 1'b0;
      board_seq_q       <= '0;
      board_ready_q     <= 1'b0;
      frame_err_q       <= 1'b0;
      out_piece_q       <= '0;
      out_piece_valid_q <= '0;
    end else begin
      state_q           <= state_d;
      wr_idx_q          <= wr_idx_d;
      live_sel_q        <= live_sel_d;
      board_seq_q       <= board_seq_d;
      board_ready_q     <= board_ready_d;
      frame_err_q       <= frame_err_d;
      out_piece_q       <= out_piece_d;
      out_piece_valid_q <= out_piece_valid_d;
    end
  end

  assign out_piece       = out_piece_q;
  assign out_piece_valid = out_piece_valid_q;
  assign board_ready     = board_ready_q;
  assign board_seq       = board_seq_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_movegen_board_store.sv
// Scoreboard bench for movegen_board_store: a frame-buffer reference model
// predicts status and lookup results; a monitor compares them.
module tb_movegen_board_store;

  localparam int unsigned PW  = 4;
  localparam int unsigned SW  = 6;
  localparam int unsigned NL  = 2;
  localparam int unsigned NSQ = 64;

  logic             clk;
  logic             rst_n;
  logic             in_pos_valid;
  logic [PW-1:0]    in_pos_data;
  logic             in_pos_sop;
  logic [NL-1:0]    lookup_valid;
  logic [NL*SW-1:0] lookup_rankfile;
  logic [NL*PW-1:0] out_piece;
  logic [NL-1:0]    out_piece_valid;
  logic             board_ready;
  logic [7:0]       board_seq;
  logic             frame_err;

  movegen_board_store #(
    .PIECE_W (PW),
    .SQ_W    (SW),
    .N_LOOKUP(NL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_pos_valid   (in_pos_valid),
    .in_pos_data    (in_pos_data),
    .in_pos_sop     (in_pos_sop),
    .lookup_valid   (lookup_valid),
    .lookup_rankfile(lookup_rankfile),
    .out_piece      (out_piece),
    .out_piece_valid(out_piece_valid),
    .board_ready    (board_ready),
    .board_seq      (board_seq),
    .frame_err      (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          ready;
    int unsigned seq;
    bit          err;
    bit [1:0]    lv;
  } status_t;

  status_t     stq[$];
  int unsigned lq0[$];
  int unsigned lq1[$];

  // Reference model: the committed board plus the frame being collected.
  int unsigned m_live[NSQ];
  bit          m_ready;
  int unsigned m_seq;
  bit          m_in_frame;
  int unsigned m_frame[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NSQ); i++) m_live[i] = 0;
    m_ready    = 0;
    m_seq      = 0;
    m_in_frame = 0;
    m_frame.delete();
  endtask

  // One cycle of stimulus, driven at the falling edge; expectations queued.
  task automatic drive(input bit v, input bit s, input int unsigned d,
                       input bit [1:0] lv, input int unsigned a0, input int unsigned a1);
    status_t st;
    bit      err;
    @(negedge clk);
    in_pos_valid    = v;
    in_pos_sop      = s;
    in_pos_data     = PW'(d);
    lookup_valid    = lv;
    lookup_rankfile = {SW'(a1), SW'(a0)};
    if (lv[0]) lq0.push_back(m_ready ? m_live[a0 % NSQ] : 0);
    if (lv[1]) lq1.push_back(m_ready ? m_live[a1 % NSQ] : 0);
    err = 0;
    if (v) begin
      if (s) begin
        if (m_in_frame) err = 1;
        m_frame.delete();
        m_frame.push_back(d % 16);
        m_in_frame = 1;
      end else if (!m_in_frame) begin
        err = 1;
      end else begin
        m_frame.push_back(d % 16);
        if (m_frame.size() == NSQ) begin
          for (int i = 0; i < int'(NSQ); i++) m_live[i] = m_frame[i];
          m_seq      = (m_seq + 1) % 256;
          m_ready    = 1;
          m_in_frame = 0;
          m_frame.delete();
        end
      end
    end
    st.ready = m_ready;
    st.seq   = m_seq;
    st.err   = err;
    st.lv    = lv;
    stq.push_back(st);
  endtask

  task automatic beat(input bit v, input bit s, input int unsigned d);
    drive(v, s, d, 2'($urandom_range(0, 3)), $urandom_range(0, NSQ-1), $urandom_range(0, NSQ-1));
  endtask

  task automatic idle_lookups(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 2'b11, $urandom_range(0, NSQ-1), $urandom_range(0, NSQ-1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    in_pos_valid = 1'b0;
    in_pos_sop   = 1'b0;
    lookup_valid = '0;
    #1;
    check("rst_out_piece", out_piece, 0);
    check("rst_out_valid", out_piece_valid, 0);
    check("rst_board_ready", board_ready, 0);
    check("rst_board_seq", board_seq, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_pending_lookups", lq0.size() + lq1.size() + stq.size(), 0);
    lq0.delete();
    lq1.delete();
    stq.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare once per cycle, shortly after the rising edge.
  always @(posedge clk) begin
    status_t     st;
    int unsigned exp;
    #1;
    if (rst_n && stq.size() > 0) begin
      st = stq.pop_front();
      check("board_ready", board_ready, st.ready);
      check("board_seq", board_seq, st.seq);
      check("frame_err", frame_err, st.err);
      check("out_piece_valid", out_piece_valid, st.lv);
      if (out_piece_valid[0]) begin
        if (lq0.size() == 0) check("port0_unexpected_resp", 1, 0);
        else begin
          exp = lq0.pop_front();
          check("port0_piece", out_piece[PW-1:0], exp);
        end
      end
      if (out_piece_valid[1]) begin
        if (lq1.size() == 0) check("port1_unexpected_resp", 1, 0);
        else begin
          exp = lq1.pop_front();
          check("port1_piece", out_piece[2*PW-1:PW], exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b1;
    in_pos_valid    = 1'b0;
    in_pos_sop      = 1'b0;
    in_pos_data     = '0;
    lookup_valid    = '0;
    lookup_rankfile = '0;
    model_reset();
    do_reset();

    // Lookup before any commit returns empty.
    drive(0, 0, 0, 2'b01, 10, 0);
    idle_lookups(2);

    // Board A: data = square index mod 16, then query squares 5 and 63.
    for (int i = 0; i < int'(NSQ); i++) beat(1, i == 0, i % 16);
    drive(0, 0, 0, 2'b11, 5, 63);

    // Board B: query square 0 during its last beat, then the cycle after.
    for (int i = 0; i < int'(NSQ); i++) begin
      if (i == int'(NSQ) - 1) drive(1, 0, $urandom_range(0, 15), 2'b01, 0, 0);
      else beat(1, i == 0, (i == 0) ? 9 : $urandom_range(0, 15));
    end
    drive(0, 0, 0, 2'b11, 0, 0);
    idle_lookups(4);

    // Restart mid-frame after 20 beats, then a full second frame.
    for (int i = 0; i < 20; i++) beat(1, i == 0, $urandom_range(0, 15));
    for (int i = 0; i < int'(NSQ); i++) beat(1, i == 0, $urandom_range(0, 15));
    idle_lookups(4);

    // Stray beat while idle.
    beat(1, 0, 7);
    idle_lookups(2);

    // Frame with random valid gaps, followed back-to-back by another frame.
    for (int i = 0; i < int'(NSQ); i++) begin
      while ($urandom_range(0, 2) == 0) beat(0, $urandom_range(0, 1) == 1, $urandom_range(0, 15));
      beat(1, i == 0, $urandom_range(0, 15));
    end
    for (int i = 0; i < int'(NSQ); i++) beat(1, i == 0, $urandom_range(0, 15));
    idle_lookups(4);

    // Reset at beat 30 of a frame; afterwards a frame must start with sop.
    for (int i = 0; i < 30; i++) beat(1, i == 0, $urandom_range(1, 15));
    do_reset();
    beat(1, 0, 3);
    idle_lookups(4);
    for (int i = 0; i < int'(NSQ); i++) beat(1, i == 0, $urandom_range(0, 15));
    idle_lookups(8);

    drive(0, 0, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 2'b00, 0, 0);
    @(posedge clk);
    #2;
    check("drain_status", stq.size(), 0);
    check("drain_port0", lq0.size(), 0);
    check("drain_port1", lq1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/movegen_board_store.md
# movegen_board_store

Parametrised, double-buffered board-position store for the move generator. Captures a streamed position (one piece code per square, start-of-packet marked) into a shadow bank, atomically swaps it live once the last square lands, and serves `N_LOOKUP` independent registered square lookups against the live bank. Sits between the position input stream and the per-piece move generators, which query occupancy by rank/file.

## Interface
- `PIECE_W`, default 4, piece code width; code 0 = empty square.
- `SQ_W`, default 6, square index width; board holds `2**SQ_W` squares.
- `N_LOOKUP`, default 2, number of independent lookup ports.

Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.

- `clk`, input, 1, clock.
- `rst_n`, input, 1, asynchronous active-low reset.
- `in_pos_valid`, input, 1, input beat valid.
- `in_pos_data`, input, `PIECE_W`, piece code for the current square.
- `in_pos_sop`, input, 1, first beat of a position (square 0).
- `lookup_valid`, input, `N_LOOKUP`, per-port lookup request.
- `lookup_rankfile`, input, `N_LOOKUP*SQ_W`, per-port square index; port i uses bits [i*SQ_W +: SQ_W].
- `out_piece`, output, `N_LOOKUP*PIECE_W`, per-port piece code.
- `out_piece_valid`, output, `N_LOOKUP`, per-port response valid.
- `board_ready`, output, 1, at least one complete position has been committed.
- `board_seq`, output, 8, count of committed positions, wraps 255→0.
- `frame_err`, output, 1, single-cycle pulse on a malformed input frame.

## Operation
- Two banks of `2**SQ_W` × `PIECE_W` registers; `live_sel` selects the bank served to lookups, the other is the shadow.
- Load FSM, states IDLE and LOAD, with square counter `wr_idx` (`SQ_W` bits):
  - IDLE: beat with sop → write data to shadow[0], `wr_idx`←1, go LOAD. Beat without sop → dropped, `frame_err` pulse.
  - LOAD: beat without sop → write shadow[`wr_idx`], `wr_idx`+1. On the beat writing square `2**SQ_W-1`: toggle `live_sel`, `board_seq`+1, `board_ready`←1, go IDLE.
  - LOAD, beat with sop → `frame_err` pulse, partial frame discarded, beat taken as square 0 of a new frame, `wr_idx`←1, stay LOAD.
- Cycles with `in_pos_valid`=0 are ignored in every state; no input backpressure.
- Lookups: port i with `lookup_valid[i]`=1 returns live[`lookup_rankfile_i`] on `out_piece` slice i. While `board_ready`=0, returns 0 (empty). `out_piece` holds its last value when not requested.
- Shadow writes never disturb live-bank reads; all ports may address the same square.

## Timing
- Reset values: `out_piece`=0, `out_piece_valid`=0, `board_ready`=0, `board_seq`=0, `frame_err`=0, `live_sel`=0, FSM=IDLE, `wr_idx`=0. Bank contents are reset to 0.
- Lookup latency 1 cycle: request in cycle t → `out_piece`/`out_piece_valid` registered at edge t+1. `out_piece_valid` is high for exactly one cycle per request.
- Commit: the bank swap occurs at the edge that writes the final square. A lookup in that same cycle reads the old board; a lookup in the next cycle reads the new board. `board_seq` and `board_ready` update at the same edge.
- `frame_err` asserts the cycle after the offending beat.
- Reset asserted mid-frame: the partial frame is lost, outputs return to reset values immediately, and the first post-reset frame must start with sop.
- Minimum commit interval is `2**SQ_W` beats; back-to-back frames (sop the cycle after the last beat) are accepted without gaps.

## Structure
- Package `movegen_pkg`: `PIECE_W`/`SQ_W` defaults, `piece_t` typedef, `PIECE_EMPTY`=0, and the load-FSM state enum.
- Sub-module `board_bank`: one register-file bank with one write port and `N_LOOKUP` combinational read ports. The top level instantiates two banks and holds the FSM, the bank select and the output registers.

## Test plan
- Stream squares 0..63 with data = index mod 16, sop on the first beat; the next cycle, look up squares 5 and 63 → 5 and 15, `board_seq`=1, `board_ready`=1.
- Lookup before any frame, square 10 → `out_piece`=0, `out_piece_valid`=1, `board_ready`=0.
- Commit board A, stream board B, and look up square 0 in the cycle of B's last beat → returns A's value; the following cycle returns B's value.
- Send sop again after 20 beats of a frame → one `frame_err` pulse; complete 64 beats from the second sop → the committed board reflects only the second frame, `board_seq` increments once.
- Beat without sop while idle → `frame_err` pulse, `board_seq` unchanged. Insert random valid gaps within a frame → the board commits correctly.
- Assert `rst_n` low at beat 30 of the second frame → all outputs 0 immediately; after release, lookups return 0 until a fresh frame commits.
